identity_comp_seq: RTL and testbench

- Sequential scheduler for the pairwise identity-comparison datapath.
- Accepts one WIDTH-bit vector over a valid/ready handshake. Walks every ordered pair (j,i) with j<i, one pair per accepted output beat, and emits the one-hot {gt,eq,lt} result per pair.
- Assembles the full packed result vector, in the same order and bit layout as the combinational identity comparator, so downstream logic can consume results either streamed or in bulk.

---
 rtl/identity_comp_seq.sv | 129 ++++++++++++
 tb/tb_identity_comp_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/identity_comp_seq.sv
// Sequential pairwise identity comparator: captures one vector, then streams one
// one-hot {gt,eq,lt} result per ordered pair (j<i) while assembling the packed result vector.
module identity_comp_seq #(
  parameter  int WIDTH = 6,
  localparam int NP    = WIDTH * (WIDTH - 1) / 2,
  localparam int IW    = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1,
  localparam int KW    = ($clog2(NP) > 1) ? $clog2(NP) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            abort,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IW-1:0]   out_j,
  output logic [IW-1:0]   out_i,
  output logic [KW-1:0]   out_k,
  output logic [2:0]      out_res,
  output logic            out_last,
  output logic [3*NP-1:0] o_vec,
  output logic            done,
  output logic            busy,
  output logic [1:0]      o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; a producer holds valid and its payload stable until that edge.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [IW-1:0] I_LAST = IW'(WIDTH - 1);
  localparam logic [KW-1:0] K_LAST = KW'(NP - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_a;
  logic [IW-1:0]     r_j;
  logic [IW-1:0]     r_i;
  logic [KW-1:0]     r_k;
  logic [3*NP-1:0]   r_vec;

  logic              w_run;
  logic              w_capture;
  logic              w_hs;
  logic              w_last;
  logic              w_a_j;
  logic              w_a_i;
  logic [2:0]        w_res;

  assign w_run     = (r_state == S_RUN);
  assign w_capture = (r_state == S_IDLE) && in_valid;
  // abort outranks the handshake, so a beat offered in an abort cycle is dropped
  assign w_hs      = w_run && out_ready && !abort;
  assign w_last    = w_run && (r_k == K_LAST);

  assign w_a_j = r_a[r_j];
  assign w_a_i = r_a[r_i];

  always_comb begin
    w_res    = 3'b000;
    w_res[0] = !w_a_j &&  w_a_i;
    w_res[1] = (w_a_j == w_a_i);
    w_res[2] =  w_a_j && !w_a_i;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_nxt = S_RUN;
      S_RUN: begin
        if (abort)                    w_state_nxt = S_IDLE;
        else if (out_ready && w_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_j     <= '0;
      r_i     <= IW'(1);
      r_k     <= '0;
      r_vec   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_a   <= in_data;
        r_j   <= '0;
        r_i   <= IW'(1);
        r_k   <= '0;
        r_vec <= '0;
      end else if (w_hs) begin
        for (int p = 0; p < NP; p++) begin
          if (r_k == KW'(p)) r_vec[3*p +: 3] <= w_res;
        end
        r_k <= r_k + KW'(1);
        // end of a row: next pair starts at (j+1, j+2)
        if (r_i == I_LAST) begin
          r_j <= r_j + IW'(1);
          r_i <= r_j + IW'(2);
        end else begin
          r_i <= r_i + IW'(1);
        end
      end
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = w_run;
  assign out_j       = r_j;
  assign out_i       = r_i;
  assign out_k       = r_k;
  assign out_res     = w_res;
  assign out_last    = w_last;
  assign o_vec       = r_vec;
  assign done        = (r_state == S_DONE);
  assign busy        = (r_state == S_RUN) || (r_state == S_DONE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_identity_comp_seq.sv
// Directed bench for identity_comp_seq: per-pair expectations are queued when a
// vector is driven and checked against every valid beat; packed results checked at done.
module tb_identity_comp_seq;

  localparam int WIDTH = 6;
  localparam int NP    = WIDTH * (WIDTH - 1) / 2;
  localparam int IW    = 3;
  localparam int KW    = 4;
  localparam int EW    = 2 * IW + KW + 4;

  logic             clk = 1'b0;
  logic             rst, abort, in_valid, out_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_ready, out_valid, out_last, done, busy;
  logic [IW-1:0]    out_j, out_i;
  logic [KW-1:0]    out_k;
  logic [2:0]       out_res;
  logic [3*NP-1:0]  o_vec;
  logic [1:0]       o_dbg_state;

  logic [EW-1:0]    exp_q[$];
  logic [3*NP-1:0]  exp_vec;
  int               n_cmp = 0;
  int               n_err = 0;

  always #5 clk = ~clk;

  identity_comp_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_j(out_j), .out_i(out_i), .out_k(out_k), .out_res(out_res),
    .out_last(out_last), .o_vec(o_vec), .done(done), .busy(busy),
    .o_dbg_state(o_dbg_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_res(input logic aj, input logic ai);
    if (aj == ai)     return 3'b010;
    else if (aj > ai) return 3'b100;
    else              return 3'b001;
  endfunction

  task automatic load_exp(input logic [WIDTH-1:0] a);
    int k;
    logic [2:0] r;
    k = 0;
    exp_vec = '0;
    for (int j = 0; j < WIDTH; j++) begin
      for (int i = j + 1; i < WIDTH; i++) begin
        r = ref_res(a[j], a[i]);
        exp_q.push_back({IW'(j), IW'(i), KW'(k), r, (k == NP - 1)});
        exp_vec[3*k +: 3] = r;
        k++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the current beat against the queue head, pops on handshake, then advances.
  task automatic step();
    logic [EW-1:0] e;
    if (out_valid) begin
      chk("beat_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        chk("out_j",    out_j,    e[EW-1 -: IW]);
        chk("out_i",    out_i,    e[EW-IW-1 -: IW]);
        chk("out_k",    out_k,    e[KW+3 -: KW]);
        chk("out_res",  out_res,  e[3:1]);
        chk("out_last", out_last, e[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    tick();
  endtask

  task automatic send_vec(input logic [WIDTH-1:0] a);
    int n;
    n = 0;
    while (!in_ready && n < 10) begin
      tick();
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    exp_q.delete();
    in_valid = 1'b1;
    in_data  = a;
    load_exp(a);
    tick();
    in_valid = 1'b0;
    chk("first_valid", out_valid, 1);
  endtask

  // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0,1 repeating
  task automatic run_vec(input logic [WIDTH-1:0] a, input int mode, input bit intrude);
    int cyc;
    send_vec(a);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      in_valid  = intrude && (cyc < 6);
      in_data   = ~a;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("run_complete", exp_q.size(), 0);
    if (mode == 0) chk("beat_cycles", cyc, NP);
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_in_ready", in_ready, 0);
    chk("done_out_valid", out_valid, 0);
    chk("o_vec", o_vec, exp_vec);
    tick();
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", in_ready, 1);
    chk("o_vec_hold", o_vec, exp_vec);
  endtask

  // Runs beats with out_ready high until the queue head is pair k_stop.
  task automatic run_until(input int k_stop);
    int cyc;
    cyc = 0;
    out_ready = 1'b1;
    while (exp_q.size() > NP - k_stop && cyc < 50) begin
      step();
      cyc++;
    end
    chk("reach_k", out_k, KW'(k_stop));
  endtask

  logic [WIDTH-1:0] a_rnd;
  logic [3*NP-1:0]  mask;

  initial begin
    rst = 1'b1; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_o_vec", o_vec, 0);
    rst = 1'b0;
    tick();

    run_vec(6'b000000, 0, 1'b0);
    run_vec(6'b000001, 0, 1'b0);
    run_vec(6'b100000, 0, 1'b0);

    a_rnd = WIDTH'($urandom_range(0, 63));
    run_vec(a_rnd, 0, 1'b0);
    run_vec(a_rnd, 1, 1'b1);
    run_vec(6'b101101, 1, 1'b1);

    // abort at pair 7: partial results kept, no done
    send_vec(6'b010110);
    run_until(7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    mask = '0;
    for (int b = 0; b < 21; b++) mask[b] = 1'b1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_o_vec", o_vec, exp_vec & mask);
    exp_q.delete();
    tick();
    chk("abort_no_late_done", done, 0);
    run_vec(6'b110011, 0, 1'b0);

    // reset mid-run at pair 3
    send_vec(6'b011010);
    run_until(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_done", done, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_out_last", out_last, 0);
    chk("mrst_o_vec", o_vec, 0);
    exp_q.delete();

    // back-to-back: second vector taken in the idle cycle right after done
    run_vec(6'b111000, 0, 1'b0);
    run_vec(6'b000111, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
